// File: rtl/multihat_pkg.sv
// Shared types and helpers for the multi-hat Gaussian accumulator.
// Optional output clipping is enabled with the GAUSS_CLIP_EN macro (see multihat_accum).
package multihat_pkg;

  localparam int HAT_W     = 17;
  localparam int MAX_BEATS = 16;  // 64 hats / 4 lanes

  typedef logic signed [HAT_W-1:0]       hat_t;
  typedef logic [$clog2(MAX_BEATS)-1:0]  beat_cnt_t;

  // Sample width grows by log2(hats) so the full sum can never overflow.
  function automatic int out_w(input int hats);
    return HAT_W + $clog2(hats);
  endfunction

  // Triangular variate: upper half minus lower half of a uniform word.
  function automatic hat_t hat_of(input logic [31:0] word);
    return $signed({1'b0, word[31:16]}) - $signed({1'b0, word[15:0]});
  endfunction

endpackage

// File: rtl/multihat_fifo.sv
// Small synchronous FIFO; an empty FIFO keeps presenting the last popped word.
module multihat_fifo #(
  parameter  int WIDTH = 21,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  // NOTE: storage has no reset; only pointers, count and the held output word need a known value.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/multihat_accum.sv
// Sums HATS_PER_SAMPLE triangular hats from four uniform lanes into Gaussian samples.
// Define GAUSS_CLIP_EN to saturate stored samples to +/-CLIP_MAG and add the clip_hit port.
module multihat_accum
  import multihat_pkg::*;
#(
  parameter  int HATS_PER_SAMPLE = 16,
  parameter  int FIFO_DEPTH      = 2,
`ifdef GAUSS_CLIP_EN
  parameter  int CLIP_MAG        = 786432,
`endif
  localparam int OUT_W           = out_w(HATS_PER_SAMPLE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_u0,
  input  logic [31:0]             in_u1,
  input  logic [31:0]             in_u2,
  input  logic [31:0]             in_u3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sample,
`ifdef GAUSS_CLIP_EN
  output logic                    clip_hit,
`endif
  output logic                    overflow_drop
);

  localparam int        BEATS     = HATS_PER_SAMPLE / 4;
  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS - 1);
  localparam int        CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int        EXT_W     = OUT_W - HAT_W;

  logic                    alive_q;
  beat_cnt_t               beat_cnt_q;
  logic                    s1_valid_q, s1_last_q;
  hat_t                    s1_hat_q [4];
  hat_t                    hat_d    [4];
  logic signed [OUT_W-1:0] acc_q, beat_sum, sample_sum, wr_value;
  logic                    drop_q;

  logic                    is_last_beat, inflight, room, accept, fifo_push;
  logic                    fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          occupancy;
  logic [OUT_W-1:0]        fifo_head;

  assign hat_d[0] = hat_of(in_u0);
  assign hat_d[1] = hat_of(in_u1);
  assign hat_d[2] = hat_of(in_u2);
  assign hat_d[3] = hat_of(in_u3);

  // A completing beat is only taken when its sample is guaranteed a FIFO slot.
  assign is_last_beat = (beat_cnt_q == LAST_BEAT);
  assign inflight     = s1_valid_q & s1_last_q;
  assign occupancy    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign room         = ~fifo_full & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign in_ready     = alive_q & (~is_last_beat | room);
  assign accept       = in_valid & in_ready;
  assign fifo_push    = inflight;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < 4; k++) begin
      beat_sum = beat_sum + {{EXT_W{s1_hat_q[k][HAT_W-1]}}, s1_hat_q[k]};
    end
  end

  assign sample_sum = acc_q + beat_sum;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive_q    <= 1'b0;
      drop_q     <= 1'b0;
      beat_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_hat_q   <= '{default: '0};
      acc_q      <= '0;
    end else begin
      alive_q    <= 1'b1;
      drop_q     <= alive_q & in_valid & ~in_ready;
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q  <= is_last_beat;
        s1_hat_q   <= hat_d;
        beat_cnt_q <= is_last_beat ? '0 : beat_cnt_q + beat_cnt_t'(1);
      end
      if (s1_valid_q) acc_q <= s1_last_q ? '0 : sample_sum;
    end
  end

`ifdef GAUSS_CLIP_EN
  localparam logic signed [OUT_W-1:0] CLIP_HI = OUT_W'(CLIP_MAG);
  localparam logic signed [OUT_W-1:0] CLIP_LO = -CLIP_HI;

  logic clipped, clip_hit_q;

  always_comb begin
    wr_value = sample_sum;
    clipped  = 1'b0;
    if (sample_sum > CLIP_HI) begin
      wr_value = CLIP_HI;
      clipped  = 1'b1;
    end else if (sample_sum < CLIP_LO) begin
      wr_value = CLIP_LO;
      clipped  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clip_hit_q <= 1'b0;
    else        clip_hit_q <= fifo_push & clipped;
  end

  assign clip_hit = clip_hit_q;
`else
  assign wr_value = sample_sum;
`endif

  multihat_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .pop_i   (out_ready),
    .data_i  (wr_value),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid     = ~fifo_empty;
  assign out_sample    = signed'(fifo_head);
  assign overflow_drop = drop_q;

endmodule

// File: tb/tb_multihat_accum.sv
// Directed bench for multihat_accum at default parameters (16 hats, 2-entry FIFO).
// Clip checks are compiled in when GAUSS_CLIP_EN is defined.
module tb_multihat_accum;

  localparam int OUT_W = 21;

  logic                    clk;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_u0, in_u1, in_u2, in_u3;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_sample;
  logic                    overflow_drop;
`ifdef GAUSS_CLIP_EN
  logic                    clip_hit;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int beats_acc;
  int pops;
  bit chk_pop;
  logic signed [31:0] exp_val;

  multihat_accum dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_u0         (in_u0),
    .in_u1         (in_u1),
    .in_u2         (in_u2),
    .in_u3         (in_u3),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sample    (out_sample),
`ifdef GAUSS_CLIP_EN
    .clip_hit      (clip_hit),
`endif
    .overflow_drop (overflow_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] w);
    in_u0 = w; in_u1 = w; in_u2 = w; in_u3 = w;
  endtask

  // One clock: handshakes are observed mid-cycle, then we land 1 unit past the edge.
  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) beats_acc++;
    if (out_valid && out_ready) begin
      pops++;
      if (chk_pop) check("pop_value", out_sample, exp_val);
    end
    @(posedge clk);
    #1;
  endtask

  // A push into a full FIFO without a simultaneous pop must never happen.
  always @(negedge clk) begin
    if (reset && dut.fifo_push)
      check("write_when_full", dut.u_fifo.full_o && !dut.u_fifo.pop_i, 0);
  end

  // Four samples of one word with out_ready held high; out_valid every 4 cycles from cycle 5.
  task automatic run_four(input logic [31:0] w, input logic signed [31:0] value, input string tag);
    set_words(w);
    exp_val   = value;
    chk_pop   = 1'b1;
    pops      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check({tag, "_valid"}, out_valid, (k == 5 || k == 9 || k == 13 || k == 17));
      if (k == 16) in_valid = 1'b0;
    end
    check({tag, "_pops"}, pops, 4);
    check({tag, "_drop"}, overflow_drop, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_words(32'h0);
    beats_acc = 0;
    pops      = 0;
    chk_pop   = 1'b0;
    exp_val   = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_drop", overflow_drop, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 16 hats of 65535 -> +1048560; reversed halves -> -1048560; equal halves -> 0.
    run_four(32'hFFFF0000, 1048560, "pos");
    run_four(32'h0000FFFF, -1048560, "neg");
    check("hold_when_empty", out_sample, -1048560);
    run_four(32'h12341234, 0, "zero");

    // Reset with one sample queued and two beats of a partial sum in progress.
    chk_pop   = 1'b0;
    out_ready = 1'b0;
    set_words(32'hFFFF0000);
    in_valid  = 1'b1;
    repeat (6) step();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_sample", out_sample, 1048560);
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sample", out_sample, 0);
    check("mid_rst_drop", overflow_drop, 0);
    @(posedge clk);
    #1;
    check("mid_rst_out_valid2", out_valid, 0);
    // Lane hats 5, -3, 16, -2 -> 16 per beat, 4 fresh beats -> 64.
    in_u0 = 32'h00070002;
    in_u1 = 32'h00010004;
    in_u2 = 32'h00100000;
    in_u3 = 32'h00000002;
    reset     = 1'b1;
    out_ready = 1'b1;
    beats_acc = 0;
    pops      = 0;
    exp_val   = 64;
    chk_pop   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (beats_acc == 4) in_valid = 1'b0;
    end
    check("rst_fresh_beats", beats_acc, 4);
    check("rst_fresh_pops", pops, 1);

    // Backpressure: hat 1 per lane -> samples of 16; FIFO fills after 8 beats.
    set_words(32'h00010000);
    out_ready = 1'b0;
    beats_acc = 0;
    pops      = 0;
    exp_val   = 16;
    in_valid  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 10) check("bp_ready_partial", in_ready, 1);
      if (k == 11) check("bp_ready_blocked", in_ready, 0);
      if (k == 12) check("bp_drop_pulse", overflow_drop, 1);
    end
    check("bp_full_valid", out_valid, 1);
    check("bp_full_sample", out_sample, 16);
    check("bp_full_drop", overflow_drop, 1);
    check("bp_beats", beats_acc, 11);
    check("bp_no_pops", pops, 0);

    for (int k = 1; k <= 20; k++) begin
      out_ready = (k % 2 == 1);
      step();
      if (out_valid) check("toggle_sample", out_sample, 16);
    end

    out_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k >= 8 && beats_acc % 4 == 0) in_valid = 1'b0;
    end
    check("bp_whole_samples", beats_acc % 4, 0);
    check("bp_no_loss", pops, beats_acc / 4);
    check("bp_drained", out_valid, 0);

`ifdef GAUSS_CLIP_EN
    chk_pop   = 1'b0;
    out_ready = 1'b0;
    set_words(32'hFFFF0000);
    in_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) in_valid = 1'b0;
    end
    check("clip_sample", out_sample, 786432);
    check("clip_hit_set", clip_hit, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    set_words(32'h00050000);
    in_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) in_valid = 1'b0;
    end
    check("noclip_sample", out_sample, 80);
    check("noclip_hit", clip_hit, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multihat_accum.md
Name: multihat_accum

Overview:
- Downstream of the four-lane 32-bit LFSR uniform generator.
- Each cycle, turns the four uniform words into four triangular "hat" variates: hat = upper half minus lower half of each word.
- Sums HATS_PER_SAMPLE hats into one approximately Gaussian signed sample.
- Delivers samples through a small output FIFO with valid/ready handshake to the scaling/consumer stage.

Parameters:
- HATS_PER_SAMPLE, 16: hats summed per output sample; multiple of 4, power of 2, range 4..64.
- FIFO_DEPTH, 2: output FIFO entries; power of 2, ≥2.
- CLIP_MAG, 21'sd786432: clip magnitude, used only with GAUSS_CLIP_EN.
- Derived constant, not overridable: OUT_W = 17 + log2(HATS_PER_SAMPLE), which is 21 at default.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  uniform words present; tied 1 when the LFSR free-runs.
- in_ready  out  1  block accepts the words this cycle.
- in_u0, in_u1, in_u2, in_u3  in  32 each  uniform words (LFSR out_32_1..4).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_sample  out  OUT_W  signed two's-complement Gaussian sample.
- overflow_drop  out  1  one-cycle pulse when in_valid=1 and in_ready=0 (uniform beat discarded).

Behaviour:
- Reset (reset low, async) clears:
  - in_ready=0, out_valid=0, out_sample=0, overflow_drop=0.
  - accumulator=0, beat counter=0, pipeline valids=0, FIFO empty.
- First cycle after reset release: in_ready=1.
- Beat accept: in_valid & in_ready.
- Stage 1, registered on accept:
  - hat_k = $signed({1'b0,u_k[31:16]}) - $signed({1'b0,u_k[15:0]}), 17-bit signed, range ±65535.
  - A last-beat flag is set when beat_cnt == HATS_PER_SAMPLE/4 - 1.
  - beat_cnt increments and wraps to 0 after the last beat.
- Stage 2:
  - beat_sum = sum of the four stage-1 hats, sign-extended to OUT_W.
  - Non-last beat: acc <= acc + beat_sum.
  - Last beat: FIFO write of acc + beat_sum, and acc <= 0 in the same cycle.
- No internal overflow: the sum of HATS_PER_SAMPLE hats always fits OUT_W.
- Latency: last beat accepted at cycle N → out_valid=1 at N+2 (FIFO previously empty). No FIFO bypass.
- Throughput: one sample per HATS_PER_SAMPLE/4 accepted beats (4 at default).
- Backpressure:
  - in_ready = (fifo_count + inflight) < FIFO_DEPTH.
  - inflight = 1 while a last-beat is in stage 1 or stage 2.
  - in_ready only gates beats that complete a sample; non-last beats are always accepted. The partial sum stays in acc and never overflows the FIFO.
  - The FIFO never overflows. Writes while full are impossible by construction; the bench asserts this.
- Output handshake:
  - out_sample is stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
- Empty FIFO: out_valid=0, out_sample holds its last value. It reads as 0 only after reset.
- Reset mid-accumulation: partial sum and in-flight beats are discarded. The next sample uses exactly HATS_PER_SAMPLE fresh hats.
- overflow_drop: registered, asserted the cycle after the dropped beat.

Optional Feature:
- Macro: GAUSS_CLIP_EN.
- Defined: the FIFO write value is saturated to [-CLIP_MAG, +CLIP_MAG] before storage. Extra output port clip_hit (1 bit) pulses with the FIFO write that was clipped.
- Undefined: values are stored unclipped and the clip_hit port does not exist.

Decomposition:
- Package multihat_pkg holds:
  - localparam HAT_W=17.
  - function out_w(hats).
  - typedef logic signed [HAT_W-1:0] hat_t.
  - typedef for beat counter width.
- Sub-module multihat_fifo: parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/count, reset async active-low.
- Hat computation and accumulator stay in the top module.

Test Plan:
- All four words 0xFFFF0000, out_ready=1, 16 beats → samples +1048560 each. First out_valid 2 cycles after beat 4, then one every 4 cycles.
- All four words 0x0000FFFF → samples -1048560. All words 0x12341234 → samples 0.
- out_ready=0 for 30 cycles, words 0x00010000:
  - FIFO fills with 2 samples of +16.
  - in_ready drops to 0 on the completing beat; overflow_drop pulses while in_valid stays 1.
  - Release out_ready → samples 16, 16, then resume with no lost or duplicated value.
- Assert reset low after 2 beats of 0xFFFF0000, release → next sample after exactly 4 new beats equals 16×hat of the new beats. All outputs are 0 during reset.
- Toggle out_ready 1/0 every cycle while full → count is stable, out_sample is stable while stalled, no write-when-full assertion fires.
- GAUSS_CLIP_EN, words 0xFFFF0000 → out_sample = +786432 with clip_hit=1. Words 0x00050000 → out_sample = 80 with clip_hit=0.
